// File: rtl/nes_fifo_pkg.sv
// nes_fifo_pkg: shared constants, count width helper and status bundle
// for the NES core synchronous FIFO.
package nes_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Bits needed to hold 0..2**depth_log2 inclusive.
  function automatic int fifo_cnt_w(input int depth_log2);
    return $clog2((1 << depth_log2) + 1);
  endfunction

endpackage

// File: rtl/nes_fifo_ram.sv
// nes_fifo_ram: simple dual-port storage, synchronous write and
// asynchronous read, left unreset so it maps onto RAM primitives.
module nes_fifo_ram #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [W-1:0]          wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [W-1:0]          rdata
);

  logic [W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nes_sync_fifo.sv
// nes_sync_fifo: single-clock FIFO with standard/FWFT read modes.
// Define NES_FIFO_WATERMARK_EN to enable the max_count peak register.
module nes_sync_fifo
  import nes_fifo_pkg::*;
#(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = (2**DEPTH_LOG2) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [W-1:0]        wr_data,
  input  logic                rd_en,
  output logic [W-1:0]        rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic                underflow,
  output logic [DEPTH_LOG2:0] max_count
);

  localparam int CW = fifo_cnt_w(DEPTH_LOG2);
  localparam int AW = DEPTH_LOG2;
  localparam logic [CW-1:0] AF_T = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_T = CW'(AE_THRESH);

  logic [CW-1:0] w_ptr, r_ptr, cnt, cnt_nxt;
  logic [W-1:0]  ram_rd, rd_q;
  logic          rd_valid_q, ovf_q, udf_q;
  logic          rd_acc, wr_acc;
  fifo_status_t  st;

  assign cnt = w_ptr - r_ptr;

  always_comb begin
    st              = '0;
    st.empty        = (w_ptr == r_ptr);
    st.full         = (w_ptr[AW-1:0] == r_ptr[AW-1:0])
                   && (w_ptr[AW] != r_ptr[AW]);
    st.almost_full  = (cnt >= AF_T);
    st.almost_empty = (cnt <= AE_T);
    st.overflow     = ovf_q;
    st.underflow    = udf_q;
  end

  // A pop frees a slot in the same edge, so a full FIFO still takes the write.
  assign rd_acc  = rd_en && !st.empty && !flush;
  assign wr_acc  = wr_en && (!st.full || rd_acc) && !flush;
  assign cnt_nxt = flush ? '0 : cnt + CW'(wr_acc) - CW'(rd_acc);

  nes_fifo_ram #(
    .W          (W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (w_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (r_ptr[AW-1:0]),
    .rdata (ram_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else if (flush) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (rd_acc) begin
        r_ptr <= r_ptr + 1'b1;
        rd_q  <= ram_rd;
      end
      rd_valid_q <= rd_acc;
      if (wr_en && st.full && !rd_acc) ovf_q <= 1'b1;
      if (rd_en && st.empty) udf_q <= 1'b1;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rd_data  = ram_rd;
      assign rd_valid = !st.empty;
    end else begin : g_std
      assign rd_data  = rd_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

`ifdef NES_FIFO_WATERMARK_EN
  logic [CW-1:0] max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) max_q <= '0;
    else if (cnt_nxt > max_q) max_q <= cnt_nxt;
  end

  assign max_count = max_q;
`else
  assign max_count = '0;
`endif

  assign empty        = st.empty;
  assign full         = st.full;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;
  assign count        = cnt;

endmodule

// File: tb/tb_nes_sync_fifo.sv
// tb_nes_sync_fifo: directed checks of a standard-mode and an FWFT
// instance, W=8, DEPTH_LOG2=2, AF_THRESH=3, AE_THRESH=1.
module tb_nes_sync_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         n_chk = 0;
  int         n_err = 0;

  logic       s_flush = 0, s_wr = 0, s_rd = 0;
  logic [7:0] s_wd = 0;
  logic [7:0] s_rdata;
  logic       s_rv, s_empty, s_full, s_af, s_ae, s_ovf, s_udf;
  logic [2:0] s_cnt, s_max;

  logic       f_flush = 0, f_wr = 0, f_rd = 0;
  logic [7:0] f_wd = 0;
  logic [7:0] f_rdata;
  logic       f_rv, f_empty, f_full, f_af, f_ae, f_ovf, f_udf;
  logic [2:0] f_cnt, f_max;

  logic [7:0] exp_q [4];

  always #5 clk = ~clk;

  nes_sync_fifo #(
    .W(8), .DEPTH_LOG2(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)
  ) u_std (
    .clk(clk), .reset(reset), .flush(s_flush),
    .wr_en(s_wr), .wr_data(s_wd), .rd_en(s_rd),
    .rd_data(s_rdata), .rd_valid(s_rv),
    .empty(s_empty), .full(s_full),
    .almost_full(s_af), .almost_empty(s_ae),
    .count(s_cnt), .overflow(s_ovf), .underflow(s_udf),
    .max_count(s_max)
  );

  nes_sync_fifo #(
    .W(8), .DEPTH_LOG2(2), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)
  ) u_fwft (
    .clk(clk), .reset(reset), .flush(f_flush),
    .wr_en(f_wr), .wr_data(f_wd), .rd_en(f_rd),
    .rd_data(f_rdata), .rd_valid(f_rv),
    .empty(f_empty), .full(f_full),
    .almost_full(f_af), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_udf),
    .max_count(f_max)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scyc(input logic w, input logic [7:0] d,
                      input logic r, input logic f);
    s_wr = w; s_wd = d; s_rd = r; s_flush = f;
    @(posedge clk); #1;
    s_wr = 0; s_rd = 0; s_flush = 0;
  endtask

  task automatic fcyc(input logic w, input logic [7:0] d,
                      input logic r);
    f_wr = w; f_wd = d; f_rd = r;
    @(posedge clk); #1;
    f_wr = 0; f_rd = 0;
  endtask

  initial begin
    exp_q[0] = 8'h11; exp_q[1] = 8'h22;
    exp_q[2] = 8'h33; exp_q[3] = 8'h44;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    chk("rst_empty", s_empty, 1);
    chk("rst_count", s_cnt, 0);
    chk("rst_rv", s_rv, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_max", s_max, 0);

    // standard fill / overflow / drain
    for (int i = 0; i < 4; i++) begin
      scyc(1, exp_q[i], 0, 0);
      if (i == 0) chk("fill1_ae", s_ae, 1);
      if (i == 1) chk("fill2_ae", s_ae, 0);
      if (i == 2) begin
        chk("fill3_af", s_af, 1);
        chk("fill3_full", s_full, 0);
      end
    end
    chk("fill_full", s_full, 1);
    chk("fill_count", s_cnt, 4);
    chk("fill_af", s_af, 1);
    chk("fill_rv", s_rv, 0);

    scyc(1, 8'h55, 0, 0);
    chk("ovf_flag", s_ovf, 1);
    chk("ovf_count", s_cnt, 4);

    for (int i = 0; i < 4; i++) begin
      scyc(0, 0, 1, 0);
      chk("drain_rv", s_rv, 1);
      chk("drain_data", s_rdata, exp_q[i]);
    end
    chk("drain_empty", s_empty, 1);
    chk("drain_count", s_cnt, 0);
    scyc(0, 0, 0, 0);
    chk("idle_rv", s_rv, 0);
    chk("idle_hold", s_rdata, 8'h44);
    chk("ovf_sticky", s_ovf, 1);

    // full with simultaneous read+write, pointers wrap past address 3
    for (int i = 0; i < 4; i++) scyc(1, exp_q[i], 0, 0);
    chk("wrap_full", s_full, 1);
    scyc(1, 8'h66, 1, 0);
    chk("simul_data", s_rdata, 8'h11);
    chk("simul_count", s_cnt, 4);
    chk("simul_full", s_full, 1);
    chk("simul_ovf", s_ovf, 1);
    for (int i = 1; i < 4; i++) begin
      scyc(0, 0, 1, 0);
      chk("wrap_data", s_rdata, exp_q[i]);
    end
    scyc(0, 0, 1, 0);
    chk("wrap_last", s_rdata, 8'h66);
    chk("wrap_empty", s_empty, 1);

    // underflow with simultaneous write into empty
    scyc(1, 8'h77, 1, 0);
    chk("udf_flag", s_udf, 1);
    chk("udf_rv", s_rv, 0);
    chk("udf_count", s_cnt, 1);
    scyc(0, 0, 1, 0);
    chk("udf_read", s_rdata, 8'h77);
    chk("udf_rv2", s_rv, 1);

    // flush with pending write
    scyc(1, 8'hA1, 0, 0);
    scyc(1, 8'hA2, 0, 0);
    scyc(1, 8'hA3, 0, 0);
    chk("pre_flush_cnt", s_cnt, 3);
    chk("pre_flush_ovf", s_ovf, 1);
    scyc(1, 8'h99, 0, 1);
    chk("flush_count", s_cnt, 0);
    chk("flush_ovf", s_ovf, 0);
    chk("flush_udf", s_udf, 0);
    chk("flush_rv", s_rv, 0);
    chk("flush_rdata", s_rdata, 8'h77);
`ifdef NES_FIFO_WATERMARK_EN
    chk("flush_max", s_max, 4);
`else
    chk("flush_max", s_max, 0);
`endif
    scyc(0, 0, 1, 0);
    chk("flush_discard_rv", s_rv, 0);
    chk("flush_discard_udf", s_udf, 1);

    // async reset in the middle of a cycle
    scyc(1, 8'hC1, 0, 0);
    scyc(1, 8'hC2, 0, 0);
    scyc(0, 0, 1, 0);
    chk("pre_rst_rv", s_rv, 1);
    chk("pre_rst_data", s_rdata, 8'hC1);
    #2 reset = 1;
    #1;
    chk("arst_rv", s_rv, 0);
    chk("arst_rdata", s_rdata, 0);
    chk("arst_count", s_cnt, 0);
    chk("arst_udf", s_udf, 0);
    chk("arst_empty", s_empty, 1);
    chk("arst_max", s_max, 0);
    @(posedge clk);
    #1 reset = 0;

    // FWFT instance
    chk("fw_rst_rv", f_rv, 0);
    fcyc(1, 8'hA5, 0);
    chk("fw_rv", f_rv, 1);
    chk("fw_data", f_rdata, 8'hA5);
    fcyc(0, 0, 0);
    chk("fw_hold", f_rdata, 8'hA5);
    fcyc(0, 0, 1);
    chk("fw_pop_rv", f_rv, 0);
    chk("fw_pop_empty", f_empty, 1);
    chk("fw_pop_udf", f_udf, 0);
    fcyc(0, 0, 1);
    chk("fw_udf", f_udf, 1);
    fcyc(1, 8'hB1, 0);
    fcyc(1, 8'hB2, 0);
    chk("fw_head1", f_rdata, 8'hB1);
    chk("fw_cnt2", f_cnt, 2);
    fcyc(0, 0, 1);
    chk("fw_head2", f_rdata, 8'hB2);
    chk("fw_cnt1", f_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
